// File: rtl/framebuffer_stream_axi_writer_if.sv
// framebuffer_stream_axi_writer_if
//   Bundles every non-clock signal of the framebuffer commit writer:
//   transfer control (s_tstart/s_taddr/s_tbytes/s_tdone), the AXIS input
//   stream (s_axis_*), the AXI4 write master channels (m_axi_aw*/w*/b*) and
//   the sticky error flag.
//   modport master : the writer itself (drives AW/W/bready, tready, tdone, error)
//   modport slave  : the surrounding system (framebuffer + memory interconnect)
//
// Handshake semantics (all channels): a transfer happens on a rising clock
// edge where valid && ready are both 1. A source holds valid and its payload
// stable until that edge; ready may toggle freely and never waits on valid.
interface framebuffer_stream_axi_writer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // transfer control
  logic                  s_tstart;
  logic [ADDR_WIDTH-1:0] s_taddr;
  logic [ADDR_WIDTH-1:0] s_tbytes;
  logic                  s_tdone;

  // AXIS input stream
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  s_axis_tlast;
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic [STRB_WIDTH-1:0] s_axis_tstrb;

  // AXI4 write address
  logic [ID_WIDTH-1:0]   m_axi_awid;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [7:0]            m_axi_awlen;
  logic [2:0]            m_axi_awsize;
  logic [1:0]            m_axi_awburst;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;

  // AXI4 write data
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [STRB_WIDTH-1:0] m_axi_wstrb;
  logic                  m_axi_wlast;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;

  // AXI4 write response
  logic [ID_WIDTH-1:0]   m_axi_bid;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;

  logic                  error;

  modport master (
    input  s_tstart, s_taddr, s_tbytes,
    input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tstrb,
    input  m_axi_awready, m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output s_tdone, s_axis_tready,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_bready, error
  );

  modport slave (
    output s_tstart, s_taddr, s_tbytes,
    output s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tstrb,
    output m_axi_awready, m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  s_tdone, s_axis_tready,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_bready, error
  );
endinterface

// File: rtl/framebuffer_stream_axi_writer.sv
// framebuffer_stream_axi_writer
//   Writes the framebuffer commit stream to memory as AXI4 INCR bursts.
//   A transfer is started by s_tstart (byte address + byte count); the AXIS
//   beats are passed straight through to the W channel, one burst in flight
//   at a time, bursts split at 2**BURST_LEN_LG beats and at 4 KiB
//   boundaries. s_tdone pulses once all bursts are acknowledged.
// Ports
//   clk, reset : clock, asynchronous active-high reset
//   bus        : framebuffer_stream_axi_writer_if.master (control, AXIS, AXI, error)
//   dbg_state  : current FSM state (IDLE=0 ADDR=1 DATA=2 RESP=3 DONE=4)
module framebuffer_stream_axi_writer #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int ID_WIDTH     = 8,
  parameter int BURST_LEN_LG = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  framebuffer_stream_axi_writer_if.master       bus,
  output logic [2:0]                            dbg_state
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int BEAT_BYTES = STRB_WIDTH;
  localparam int SIZE_LG    = $clog2(BEAT_BYTES);
  localparam int MAX_BEATS  = 1 << BURST_LEN_LG;
  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_RESP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] beats_left_q, beats_left_d;
  logic [8:0]            burst_cnt_q, burst_cnt_d;
  logic [8:0]            len_q, len_d;
  logic                  awvalid_q, awvalid_d;
  logic                  error_q, error_d;
  logic                  tdone_q, tdone_d;

  logic [12:0]           bdry_bytes;
  logic [12:0]           bdry_beats;
  logic [8:0]            len_c;
  logic                  in_data;
  logic                  w_hs;
  logic                  final_beat;

  // Burst length: the smallest of the remaining beats, the burst cap and
  // the beats left before the next 4 KiB page. Only sampled in ADDR, where
  // addr_q/beats_left_q are stable, so awlen stays stable until awready.
  always_comb begin
    bdry_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
    bdry_beats = bdry_bytes >> SIZE_LG;
    len_c      = 9'(MAX_BEATS);
    if (bdry_beats < 13'(len_c)) len_c = bdry_beats[8:0];
    if (beats_left_q < ADDR_WIDTH'(len_c)) len_c = beats_left_q[8:0];
  end

  assign in_data    = (state_q == ST_DATA);
  assign w_hs       = in_data && bus.s_axis_tvalid && bus.m_axi_wready;
  assign final_beat = (beats_left_q == ONE_A);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beats_left_d = beats_left_q;
    burst_cnt_d  = burst_cnt_q;
    len_d        = len_q;
    awvalid_d    = awvalid_q;
    error_d      = error_q;
    tdone_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.s_tstart) begin
          addr_d       = bus.s_taddr;
          beats_left_d = bus.s_tbytes >> SIZE_LG;
          error_d      = 1'b0;
          if (bus.s_tbytes == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_ADDR;
            awvalid_d = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (awvalid_q && bus.m_axi_awready) begin
          awvalid_d   = 1'b0;
          burst_cnt_d = len_c;
          len_d       = len_c;
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          burst_cnt_d  = burst_cnt_q - 9'd1;
          beats_left_d = beats_left_q - ONE_A;
          // Framing comes from the byte count; tlast is only cross-checked.
          if (bus.s_axis_tlast != final_beat) error_d = 1'b1;
          if (burst_cnt_q == 9'd1) begin
            addr_d  = addr_q + (ADDR_WIDTH'(len_q) << SIZE_LG);
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (bus.m_axi_bvalid) begin
          if (bus.m_axi_bresp != 2'b00) error_d = 1'b1;
          if (beats_left_q != '0) begin
            state_d   = ST_ADDR;
            awvalid_d = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // tdone is registered, so the pulse appears as the FSM re-enters IDLE.
        tdone_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      beats_left_q <= '0;
      burst_cnt_q  <= '0;
      len_q        <= '0;
      awvalid_q    <= 1'b0;
      error_q      <= 1'b0;
      tdone_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beats_left_q <= beats_left_d;
      burst_cnt_q  <= burst_cnt_d;
      len_q        <= len_d;
      awvalid_q    <= awvalid_d;
      error_q      <= error_d;
      tdone_q      <= tdone_d;
    end
  end

  assign bus.m_axi_awid    = '0;
  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awlen   = 8'(len_c - 9'd1);
  assign bus.m_axi_awsize  = 3'(SIZE_LG);
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_awvalid = awvalid_q;

  // Unbuffered pass-through; both directions are gated off outside DATA.
  assign bus.m_axi_wdata   = bus.s_axis_tdata;
  assign bus.m_axi_wstrb   = bus.s_axis_tstrb;
  assign bus.m_axi_wlast   = in_data && (burst_cnt_q == 9'd1);
  assign bus.m_axi_wvalid  = in_data && bus.s_axis_tvalid;
  assign bus.s_axis_tready = in_data && bus.m_axi_wready;

  assign bus.m_axi_bready  = (state_q == ST_RESP);
  assign bus.s_tdone       = tdone_q;
  assign bus.error         = error_q;
  assign dbg_state         = state_q;

  // Response ID carries no information with a single outstanding burst.
  logic unused_bid;
  assign unused_bid = ^bus.m_axi_bid;

endmodule

// File: tb/tb_framebuffer_stream_axi_writer.sv
module tb_framebuffer_stream_axi_writer;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 8;
  localparam int SW = DW / 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  framebuffer_stream_axi_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus();

  framebuffer_stream_axi_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .BURST_LEN_LG(4)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int tstart_cyc = 0;
  int w_hs_cnt = 0;
  int b_pending = 0;
  bit stall = 1'b0;
  bit in_data = 1'b0;

  logic [AW+7:0]  exp_aw_q[$];     // {awaddr, awlen}
  logic [DW+SW:0] exp_w_q[$];      // {wdata, wstrb, wlast}
  logic [DW+SW:0] stream_q[$];     // {tlast, tstrb, tdata}
  logic [1:0]     bresp_plan_q[$];
  logic           exp_err_q[$];
  int             exp_lat_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: DUT produced an event with nothing expected (cycle %0d)", name, cyc);
  endtask

  task automatic flush_model();
    exp_aw_q.delete();
    exp_w_q.delete();
    stream_q.delete();
    bresp_plan_q.delete();
    exp_err_q.delete();
    exp_lat_q.delete();
    b_pending = 0;
    in_data = 1'b0;
    bus.m_axi_bvalid = 1'b0;
  endtask

  // ---------------- slave-side drivers ----------------
  initial begin
    bus.s_tstart = 1'b0; bus.s_taddr = '0; bus.s_tbytes = '0;
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
    bus.s_axis_tdata = '0; bus.s_axis_tstrb = '0;
    bus.m_axi_awready = 1'b1; bus.m_axi_wready = 1'b1;
    bus.m_axi_bid = '0; bus.m_axi_bresp = 2'b00; bus.m_axi_bvalid = 1'b0;
  end

  // AW / W readiness of the memory side
  initial forever begin
    @(posedge clk); #1;
    bus.m_axi_awready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
    bus.m_axi_wready  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // AXIS source: holds a presented beat until it is accepted
  initial begin
    bit shs;
    forever begin
      @(negedge clk);
      shs = bus.s_axis_tvalid && bus.s_axis_tready;
      @(posedge clk); #1;
      if (shs && stream_q.size() > 0) void'(stream_q.pop_front());
      if (stream_q.size() == 0) begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = DW'($urandom);
        bus.s_axis_tstrb  = SW'($urandom);
        bus.s_axis_tlast  = 1'b0;
      end else begin
        if (!(bus.s_axis_tvalid && !shs))
          bus.s_axis_tvalid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        {bus.s_axis_tlast, bus.s_axis_tstrb, bus.s_axis_tdata} = stream_q[0];
      end
    end
  end

  // B responder: one response per completed burst, in order
  initial begin
    bit bhs;
    forever begin
      @(negedge clk);
      bhs = bus.m_axi_bvalid && bus.m_axi_bready;
      @(posedge clk); #1;
      bus.m_axi_bid = IW'($urandom);
      if (bhs) begin
        bus.m_axi_bvalid = 1'b0;
        if (b_pending > 0) b_pending--;
      end else if (!bus.m_axi_bvalid && b_pending > 0 &&
                   (!stall || $urandom_range(0, 2) == 0)) begin
        bus.m_axi_bvalid = 1'b1;
        bus.m_axi_bresp  = (bresp_plan_q.size() > 0) ? bresp_plan_q.pop_front() : 2'b00;
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin
    bit            aw_wait;
    logic [AW+7:0] aw_prev;
    aw_wait = 1'b0;
    aw_prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        aw_wait = 1'b0;
      end else begin
        if (aw_wait) begin
          check("awvalid_held", 64'(bus.m_axi_awvalid), 64'(1));
          check("aw_stable", 64'({bus.m_axi_awaddr, bus.m_axi_awlen}), 64'(aw_prev));
        end
        aw_wait = 1'b0;
        if (bus.m_axi_awvalid) begin
          if (bus.m_axi_awready) begin
            check("aw_fixed", 64'({bus.m_axi_awid, bus.m_axi_awsize, bus.m_axi_awburst}),
                  64'({8'h00, 3'd2, 2'b01}));
            if (exp_aw_q.size() == 0) unexpected("aw_burst");
            else check("aw_burst", 64'({bus.m_axi_awaddr, bus.m_axi_awlen}), 64'(exp_aw_q.pop_front()));
            in_data = 1'b1;
          end else begin
            aw_wait = 1'b1;
            aw_prev = {bus.m_axi_awaddr, bus.m_axi_awlen};
          end
        end
      end
    end
  end

  initial begin
    logic [DW+SW:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.s_axis_tready) check("tready_in_data", 64'(in_data), 64'(1));
        if (bus.m_axi_wvalid && bus.m_axi_wready) begin
          w_hs_cnt++;
          if (exp_w_q.size() == 0) unexpected("w_beat");
          else begin
            e = exp_w_q.pop_front();
            check("w_beat", 64'({bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_wlast}), 64'(e));
            if (e[0]) begin
              in_data = 1'b0;
              b_pending++;
            end
          end
        end
      end
    end
  end

  initial begin
    int lat;
    forever begin
      @(negedge clk);
      if (!reset && bus.s_tdone) begin
        if (exp_err_q.size() == 0) unexpected("tdone");
        else begin
          check("error_at_done", 64'(bus.error), 64'(exp_err_q.pop_front()));
          lat = exp_lat_q.pop_front();
          if (lat >= 0) check("tdone_latency", 64'(cyc - tstart_cyc), 64'(lat));
        end
      end
    end
  end

  // ---------------- stimulus / reference model ----------------
  // Bursts: greedy split by remaining beats, 16-beat cap and 4 KiB page end.
  task automatic start_transfer(input logic [AW-1:0] addr, input int beats,
                                input int bad_b, input int bad_tlast);
    logic [AW-1:0] a;
    int left, bi, idx, len, room;
    bit exp_err;
    a = addr; left = beats; bi = 0; idx = 0; exp_err = 1'b0;
    while (left > 0) begin
      room = (4096 - int'(a & 32'hFFF)) / SW;
      len = left;
      if (len > 16) len = 16;
      if (len > room) len = room;
      exp_aw_q.push_back({a, 8'(len - 1)});
      bresp_plan_q.push_back((bi == bad_b) ? 2'b10 : 2'b00);
      if (bi == bad_b) exp_err = 1'b1;
      for (int j = 0; j < len; j++) begin
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic          tl;
        d = DW'($urandom);
        s = SW'($urandom);
        tl = (idx == beats - 1);
        if (idx == bad_tlast) begin
          tl = ~tl;
          exp_err = 1'b1;
        end
        stream_q.push_back({tl, s, d});
        exp_w_q.push_back({d, s, (j == len - 1)});
        idx++;
      end
      a = a + AW'(len * SW);
      left -= len;
      bi++;
    end
    exp_err_q.push_back(exp_err);
    exp_lat_q.push_back((beats == 0) ? 2 : -1);

    @(posedge clk); #1;
    bus.s_tstart = 1'b1;
    bus.s_taddr  = addr;
    bus.s_tbytes = AW'(beats * SW);
    @(negedge clk);
    tstart_cyc = cyc;
    @(posedge clk); #1;
    bus.s_tstart = 1'b0;
    bus.s_taddr  = AW'($urandom);
    bus.s_tbytes = AW'($urandom);
    check("error_cleared", 64'(bus.error), 64'(0));
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    flush_model();
    #1;
    check("reset_outputs", 64'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.s_axis_tready,
                                bus.m_axi_bready, bus.s_tdone, bus.error}), 64'(0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_err_q.size() != 0 && n < 8000) begin
      @(posedge clk);
      n++;
    end
    if (exp_err_q.size() != 0) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL transfer_timeout: no tdone after %0d cycles, expected one", n);
      pulse_reset();
    end else begin
      check("aw_leftover", 64'(exp_aw_q.size()), 64'(0));
      check("w_leftover", 64'(exp_w_q.size()), 64'(0));
    end
  endtask

  task automatic do_transfer(input logic [AW-1:0] addr, input int beats,
                             input int bad_b, input int bad_tlast);
    start_transfer(addr, beats, bad_b, bad_tlast);
    wait_done();
  endtask

  initial begin
    int start_w, n, beats, bad_b;
    logic [AW-1:0] a;

    // reset state, with the upstream/downstream trying to handshake
    bus.s_axis_tvalid = 1'b1;
    #12;
    check("reset_outputs", 64'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.s_axis_tready,
                                bus.m_axi_bready, bus.s_tdone, bus.error}), 64'(0));
    bus.s_axis_tvalid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;

    // directed, no stalls
    do_transfer(32'h0000_1000, 16, -1, -1);
    do_transfer(32'h0000_0FF8, 8, -1, -1);
    do_transfer(32'h0000_4000, 0, -1, -1);

    // directed, random stalls everywhere
    stall = 1'b1;
    do_transfer(32'h0002_0F00, 100, -1, -1);
    do_transfer(32'h0000_2000, 48, 1, -1);
    do_transfer(32'h0000_3000, 5, -1, -1);
    do_transfer(32'h0000_5000, 10, -1, 3);
    do_transfer(32'h0000_5100, 7, -1, 6);
    do_transfer(32'hFFFF_FFF0, 12, -1, -1);
    do_transfer(32'h0000_7000, 0, -1, -1);

    // random transfers, biased towards page ends
    for (int t = 0; t < 10; t++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 1) == 1) a[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
      a[1:0] = 2'b00;
      beats = $urandom_range(0, 40);
      bad_b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
      do_transfer(a, beats, bad_b, -1);
    end

    // reset in the middle of a data burst, then a clean transfer
    start_w = w_hs_cnt;
    start_transfer(32'h0000_6000, 40, -1, -1);
    n = 0;
    while (w_hs_cnt < start_w + 5 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("mid_data_progress", 64'(w_hs_cnt >= start_w + 5), 64'(1));
    pulse_reset();
    do_transfer(32'h0000_6000, 20, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
